// File: rtl/tia_hmove_controller.sv
// HMOVE sequencer: holds the HM registers, runs the motion counter and issues extra object clocks.
// Latency: hmove arms next clk; extra_clk pulses are registered and appear the clk after a motion tick.
// Backpressure: none; strobes are always accepted, and writes or hmove during a sequence retarget it on the fly.
module tia_hmove_controller #(
   parameter int NUM_OBJ = 5,
   parameter int CNT_W   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     motck_tick,
   input  logic                     hmove,
   input  logic                     hm_we,
   input  logic [2:0]               hm_sel,
   input  logic [CNT_W-1:0]         hm_wdata,
   input  logic                     hmclr,
   output logic [NUM_OBJ-1:0]       extra_clk,
   output logic                     sec,
   output logic                     busy,
   output logic [NUM_OBJ*CNT_W-1:0] hm_out
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_MOVING = 2'd2
   } state_t;

   // Flipping the sign bit maps the signed motion value onto the unsigned counter range.
   localparam logic [CNT_W-1:0] KEY_FLIP = {1'b1, {(CNT_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t                          state_q, state_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [NUM_OBJ-1:0]              en_q, en_d;
   logic [NUM_OBJ-1:0]              pulse_q, pulse_d;
   logic [NUM_OBJ-1:0][CNT_W-1:0]   hm_q, hm_d;

   // Next-state logic: HM register updates plus the arm/move sequencing.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      pulse_d = '0;
      hm_d    = hm_q;

      // A clear overrides a same-cycle write; out-of-range selects match no object.
      if (hmclr) begin
         hm_d = '0;
      end else if (hm_we) begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            if (hm_sel == 3'(i)) begin
               hm_d[i] = hm_wdata;
            end
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (hmove) begin
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            // The arming tick only loads the counter; it never pulses.
            if (motck_tick) begin
               state_d = ST_MOVING;
               cnt_d   = CNT_MAX;
               en_d    = '1;
            end
         end
         ST_MOVING: begin
            if (motck_tick) begin
               for (int i = 0; i < NUM_OBJ; i++) begin
                  if (en_q[i] && ((hm_q[i] ^ KEY_FLIP) == cnt_q)) begin
                     en_d[i] = 1'b0;
                  end else if (en_q[i]) begin
                     pulse_d[i] = 1'b1;
                  end
               end
               if (cnt_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            // Retrigger: the current tick is still evaluated, then we wait to re-arm.
            if (hmove) begin
               state_d = ST_ARMED;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; reset drops any pending pulse immediately.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         en_q    <= '0;
         pulse_q <= '0;
         hm_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         pulse_q <= pulse_d;
         hm_q    <= hm_d;
      end
   end

   assign extra_clk = pulse_q;
   assign busy      = (state_q != ST_IDLE);
   assign sec       = (state_q == ST_ARMED) || (state_q == ST_MOVING);
   assign hm_out    = hm_q;

endmodule

// File: tb/tb_tia_hmove_controller.sv
// Bench for tia_hmove_controller: directed scenarios plus random traffic against a reference model.
// Latency: model predicts outputs one clk after the inputs are applied.
// Backpressure: none; the bench spaces motion ticks at least 4 clks apart.
module tb_tia_hmove_controller;

   logic        clk;
   logic        reset;
   logic        motck_tick;
   logic        hmove;
   logic        hm_we;
   logic [2:0]  hm_sel;
   logic [3:0]  hm_wdata;
   logic        hmclr;
   logic [4:0]  extra_clk;
   logic        sec;
   logic        busy;
   logic [19:0] hm_out;

   tia_hmove_controller #(.NUM_OBJ(5), .CNT_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .motck_tick (motck_tick),
      .hmove      (hmove),
      .hm_we      (hm_we),
      .hm_sel     (hm_sel),
      .hm_wdata   (hm_wdata),
      .hmclr      (hmclr),
      .extra_clk  (extra_clk),
      .sec        (sec),
      .busy       (busy),
      .hm_out     (hm_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: mode 0 idle, 1 armed, 2 moving; evals counts evaluating ticks of the run.
   int m_mode;
   int m_evals;
   int m_hm   [5];
   bit m_done [5];
   bit [4:0] m_pulse;
   int m_tot  [5];
   int d_tot  [5];
   logic [4:0] prev_extra;
   bit sec_dropped;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input bit tk, input bit hv, input bit we, input int sel,
                             input int wd, input bit clr, input bit rs);
      m_pulse = '0;
      if (rs) begin
         m_mode  = 0;
         m_evals = 0;
         for (int i = 0; i < 5; i++) begin
            m_hm[i]   = 0;
            m_done[i] = 1'b1;
         end
         return;
      end
      if (m_mode == 1 && tk) begin
         m_mode  = 2;
         m_evals = 0;
         for (int i = 0; i < 5; i++) m_done[i] = 1'b0;
      end else if (m_mode == 2) begin
         if (tk) begin
            // The counter value seen at this tick is 15 minus the ticks already evaluated.
            for (int i = 0; i < 5; i++) begin
               if (!m_done[i]) begin
                  if ((m_hm[i] ^ 8) == 15 - m_evals) m_done[i] = 1'b1;
                  else m_pulse[i] = 1'b1;
               end
            end
            m_evals++;
            if (m_evals == 16) m_mode = 0;
         end
         if (hv) m_mode = 1;
      end else if (m_mode == 0 && hv) begin
         m_mode = 1;
      end
      if (clr) begin
         for (int i = 0; i < 5; i++) m_hm[i] = 0;
      end else if (we && sel < 5) begin
         m_hm[sel] = wd;
      end
   endtask

   task automatic cyc(input bit tk, input bit hv, input bit we, input int sel,
                      input int wd, input bit clr, input bit rs);
      logic [19:0] exp_hm;
      @(negedge clk);
      motck_tick = tk;
      hmove      = hv;
      hm_we      = we;
      hm_sel     = 3'(sel);
      hm_wdata   = 4'(wd);
      hmclr      = clr;
      reset      = rs;
      @(posedge clk);
      model_step(tk, hv, we, sel, wd, clr, rs);
      #1;
      exp_hm = '0;
      for (int i = 0; i < 5; i++) begin
         exp_hm = exp_hm | (20'(m_hm[i]) << (4 * i));
         d_tot[i] += int'(extra_clk[i]);
         m_tot[i] += int'(m_pulse[i]);
      end
      check_val("extra_clk", 32'(extra_clk), 32'(m_pulse));
      check_val("busy", 32'(busy), 32'(m_mode != 0));
      check_val("sec", 32'(sec), 32'(m_mode != 0));
      check_val("hm_out", 32'(hm_out), 32'(exp_hm));
      check_val("no_back2back", 32'(extra_clk & prev_extra), 32'd0);
      prev_extra = extra_clk;
      if (!sec) sec_dropped = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1, 0, 0, 0, 0, 0, 0);
         idle(3);
      end
   endtask

   task automatic wr(input int sel, input int wd);
      cyc(0, 0, 1, sel, wd, 0, 0);
   endtask

   task automatic clr_tot();
      for (int i = 0; i < 5; i++) begin
         d_tot[i] = 0;
         m_tot[i] = 0;
      end
   endtask

   task automatic cmp_tot(input string tag);
      for (int i = 0; i < 5; i++) check_val(tag, 32'(d_tot[i]), 32'(m_tot[i]));
   endtask

   initial begin
      int gap;
      motck_tick = 0; hmove = 0; hm_we = 0; hm_sel = 0; hm_wdata = 0; hmclr = 0; reset = 1;
      prev_extra = '0;
      sec_dropped = 1'b0;
      m_mode = 0; m_evals = 0;
      for (int i = 0; i < 5; i++) begin m_hm[i] = 0; m_done[i] = 1'b1; end
      clr_tot();

      // Reset and idle ticks.
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      check_val("rst_hm_out", 32'(hm_out), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      tick_n(20);
      for (int i = 0; i < 5; i++) check_val("idle_pulses", 32'(d_tot[i]), 32'd0);

      // Basic counts.
      wr(0, 4'h7); wr(1, 4'h0); wr(2, 4'h8); wr(3, 4'hF); wr(4, 4'h1);
      clr_tot();
      cyc(0, 1, 0, 0, 0, 0, 0);
      idle(2);
      tick_n(17);
      check_val("basic_p0", 32'(d_tot[0]), 32'd0);
      check_val("basic_p1", 32'(d_tot[1]), 32'd7);
      check_val("basic_m0", 32'(d_tot[2]), 32'd15);
      check_val("basic_m1", 32'(d_tot[3]), 32'd8);
      check_val("basic_bl", 32'(d_tot[4]), 32'd6);
      check_val("basic_busy_end", 32'(busy), 32'd0);
      cmp_tot("basic_model");

      // Mid-sequence write.
      cyc(0, 0, 0, 0, 0, 1, 0);
      wr(0, 4'h8);
      clr_tot();
      cyc(0, 1, 0, 0, 0, 0, 0);
      idle(2);
      tick_n(6);
      check_val("mid_p0_first5", 32'(d_tot[0]), 32'd5);
      wr(0, 4'hC);
      tick_n(11);
      check_val("mid_p0_total", 32'(d_tot[0]), 32'd11);
      cmp_tot("mid_model");

      // hmclr beats a simultaneous write.
      wr(1, 4'h5);
      cyc(0, 0, 1, 2, 4'h3, 1, 0);
      check_val("hmclr_wins", 32'(hm_out), 32'd0);

      // Retrigger with a coincident hmove on evaluating tick 6.
      wr(4, 4'h0);
      clr_tot();
      cyc(0, 1, 0, 0, 0, 0, 0);
      idle(2);
      sec_dropped = 1'b0;
      tick_n(6);
      cyc(1, 1, 0, 0, 0, 0, 0);
      idle(3);
      check_val("retrig_first", 32'(d_tot[4]), 32'd6);
      check_val("retrig_armed_sec", 32'(sec), 32'd1);
      tick_n(16);
      check_val("retrig_sec_held", 32'(sec_dropped), 32'd0);
      tick_n(1);
      check_val("retrig_total", 32'(d_tot[4]), 32'd13);
      check_val("retrig_busy_end", 32'(busy), 32'd0);

      // Reset in the middle of a sequence.
      cyc(0, 0, 0, 0, 0, 1, 0);
      wr(1, 4'h8);
      clr_tot();
      cyc(0, 1, 0, 0, 0, 0, 0);
      idle(2);
      tick_n(4);
      check_val("rst_mid_before", 32'(d_tot[1]), 32'd3);
      cyc(0, 0, 0, 0, 0, 0, 1);
      check_val("rst_mid_busy", 32'(busy), 32'd0);
      check_val("rst_mid_hm", 32'(hm_out), 32'd0);
      tick_n(10);
      check_val("rst_mid_after", 32'(d_tot[1]), 32'd3);

      // Random traffic against the model.
      clr_tot();
      gap = 4;
      for (int c = 0; c < 4000; c++) begin
         bit tk, hv, we, cl, rs;
         int sel, wd;
         tk = 1'b0;
         if (gap == 0) begin
            tk  = 1'b1;
            gap = int'($urandom_range(3, 7));
         end else begin
            gap--;
         end
         hv  = ($urandom_range(0, 39) == 0);
         we  = ($urandom_range(0, 5) == 0);
         sel = int'($urandom_range(0, 7));
         wd  = int'($urandom_range(0, 15));
         cl  = ($urandom_range(0, 99) == 0);
         rs  = ($urandom_range(0, 499) == 0);
         cyc(tk, hv, we, sel, wd, cl, rs);
      end
      cmp_tot("rand_totals");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tia_hmove_controller.md
Name: tia_hmove_controller

Overview:
- Sequences the horizontal-motion (HMOVE) cycle of the TIA horizontal timing path.
- On an HMOVE strobe it runs a 4-bit motion counter, stepped by the motion clock tick from the horizontal timing block.
- During that cycle it issues extra clock pulses to each movable object's position counter (P0, P1, M0, M1, BL), according to that object's 4-bit HM register.
- It also holds the HM registers and drives the extended-blank (sec) flag.

Parameters:
- NUM_OBJ, 5, number of movable objects (index 0=P0, 1=P1, 2=M0, 3=M1, 4=BL).
- CNT_W, 4, width of the motion counter and of each HM register.

Ports:
- clk  input  1  color clock.
- reset  input  1  synchronous, active-high reset.
- motck_tick  input  1  one-clk pulse per motion clock period, from horizontal timing.
- hmove  input  1  one-clk strobe, HMOVE register write.
- hm_we  input  1  HM register write enable.
- hm_sel  input  3  HM register index 0..NUM_OBJ-1; values >= NUM_OBJ are ignored.
- hm_wdata  input  CNT_W  HM write data, two's-complement motion value.
- hmclr  input  1  one-clk strobe, clears all HM registers.
- extra_clk  output  NUM_OBJ  one-clk extra clock pulse per object.
- sec  output  1  extended blank; high while ARMED or MOVING.
- busy  output  1  high while state != IDLE.
- hm_out  output  NUM_OBJ*CNT_W  current HM registers, object i at bits [4i+3:4i].

Behaviour:
- Reset (synchronous, sampled on clk edge):
  - state=IDLE, cnt=0, all HM=0, enable latches=0.
  - extra_clk=0, sec=0, busy=0.
  - Reset mid-sequence aborts immediately; no further pulses are issued.
- HM registers:
  - hm_we writes hm_wdata to HM[hm_sel] at the clock edge.
  - hmclr zeroes all HM registers.
  - hmclr and hm_we in the same cycle: hmclr wins.
  - Writes are legal in any state and take effect at the next comparison, so a mid-sequence change affects remaining pulses.
- Compare key for object i: k_i = HM[i] XOR 4'b1000 (unsigned 0..15).
- States:
  - IDLE: hmove -> ARMED next cycle.
  - ARMED: on motck_tick -> MOVING, cnt=15, all enable latches=1. No pulses on this tick.
  - MOVING, on each motck_tick, evaluate every object i:
    - if en_i and k_i==cnt: clear en_i, no pulse.
    - else if en_i: extra_clk[i]=1 for exactly one clk cycle, registered, in the cycle after the tick.
    - then: if cnt==0 -> IDLE, else cnt=cnt-1.
  - Cleared enable latches stay cleared until the next ARMED->MOVING transition.
- Pulse count with HM constant = 15 - k_i. Examples:
  - HM=0x7 -> 0 pulses.
  - HM=0x0 -> 7 pulses.
  - HM=0x8 -> 15 pulses.
- MOVING lasts 16 evaluating ticks after the arming tick. busy/sec fall in the cycle after the cnt==0 evaluation.
- hmove while ARMED: no effect.
- hmove while MOVING: state -> ARMED next cycle, cnt is held, no pulses until re-armed. The next tick restarts at cnt=15 with all enables set.
- hmove coincident with motck_tick in MOVING: the evaluation for that tick still happens, then the state goes ARMED.
- motck_tick in IDLE: ignored.
- extra_clk is never asserted for two consecutive clk cycles. Ticks are at least 4 clks apart by contract.

Test Plan:
- Reset, then idle ticks: 20 motck_tick with no hmove -> extra_clk stays 0; sec=busy=0; hm_out=0.
- Basic counts: HM=0x7,0x0,0x8,0xF,0x1 for P0..BL; hmove; 17 ticks -> pulse counts 0,7,15,8,6; busy low after the 17th tick.
- Mid-sequence write: HM[P0]=0x8; hmove; after 5 evaluating ticks (5 pulses) write HM[P0]=0xC (k=4) -> P0 total 11 pulses.
- hmclr with simultaneous hm_we HM[M0]=0x3 -> all hm_out=0.
- Retrigger: hmove at evaluating tick 6 with HM[BL]=0x0 -> 6 pulses, then re-arm; the restarted sequence gives 7 more (13 total); sec stays high throughout.
- Reset asserted mid-MOVING, HM[P1]=0x8 after 3 pulses -> no further pulses; state IDLE; HM=0 next cycle.
